// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for the shared unified memory port.
// One access in flight at a time; read data is passed through during the response cycle.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [2:0]        m0_funct3,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [2:0]        m1_funct3,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_write_en,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic [ADDR_W-1:0] mem_read_address,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam int unsigned      CNT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              owner;
  logic              rr_ptr;
  logic              cap_we;
  logic [CNT_W-1:0]  lat_cnt;
  logic              any_req;
  logic              winner;
  logic              sel_we;
  logic [2:0]        sel_funct3;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              access_done;

  // Arbitration, request mux and next-state decode.
  always_comb begin
    any_req     = m0_req | m1_req;
    winner      = (m0_req & m1_req) ? rr_ptr : m1_req;
    sel_we      = winner ? m1_we     : m0_we;
    sel_funct3  = winner ? m1_funct3 : m0_funct3;
    sel_addr    = winner ? m1_addr   : m0_addr;
    sel_wdata   = winner ? m1_wdata  : m0_wdata;
    access_done = cap_we | (lat_cnt == LAT_LAST);
    state_nxt   = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  if (access_done) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, capture registers and registered strobes; mem_* hold the captured request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      owner             <= 1'b0;
      rr_ptr            <= 1'b0;
      cap_we            <= 1'b0;
      lat_cnt           <= '0;
      m0_gnt            <= 1'b0;
      m1_gnt            <= 1'b0;
      m0_rvalid         <= 1'b0;
      m1_rvalid         <= 1'b0;
      mem_write_en      <= 1'b0;
      mem_funct3        <= '0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      mem_read_address  <= '0;
    end else begin
      state     <= state_nxt;
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner             <= winner;
            rr_ptr            <= ~winner;
            cap_we            <= sel_we;
            lat_cnt           <= '0;
            m0_gnt            <= ~winner;
            m1_gnt            <= winner;
            mem_write_en      <= sel_we;
            mem_funct3        <= sel_funct3;
            mem_write_address <= sel_we ? sel_addr  : '0;
            mem_write_data    <= sel_we ? sel_wdata : '0;
            mem_read_address  <= sel_we ? '0 : sel_addr;
          end
        end
        ACCESS: begin
          mem_write_en <= 1'b0;
          if (access_done) begin
            m0_rvalid <= ~owner;
            m1_rvalid <= owner;
          end else begin
            lat_cnt <= lat_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          cap_we            <= 1'b0;
          mem_funct3        <= '0;
          mem_write_address <= '0;
          mem_write_data    <= '0;
          mem_read_address  <= '0;
        end
        default: ;
      endcase
    end
  end

  // Read data reaches only the owner, and only for a read response.
  always_comb begin
    m0_rdata = '0;
    m1_rdata = '0;
    if (state == RESP && !cap_we) begin
      if (owner) m1_rdata = mem_read_data;
      else       m0_rdata = mem_read_data;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: random two-requester traffic against an access-timeline model,
// plus directed latency, alternation, late-request, reset-abort and long-latency scenarios.
module tb_mem_port_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned RL  = 1;
  localparam int unsigned RL3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [2:0]    m0_funct3, m1_funct3;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_write_en;
  logic [2:0]    mem_funct3;
  logic [AW-1:0] mem_write_address, mem_read_address;
  logic [DW-1:0] mem_write_data;
  logic [DW-1:0] mem_read_data = '0;

  // Second instance with a three-cycle memory.
  logic          b_m0_req, b_m0_we, b_m1_req, b_m1_we;
  logic [2:0]    b_m0_funct3, b_m1_funct3;
  logic [AW-1:0] b_m0_addr, b_m1_addr;
  logic [DW-1:0] b_m0_wdata, b_m1_wdata;
  logic          b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid;
  logic [DW-1:0] b_m0_rdata, b_m1_rdata;
  logic          b_mem_write_en;
  logic [2:0]    b_mem_funct3;
  logic [AW-1:0] b_mem_write_address, b_mem_read_address;
  logic [DW-1:0] b_mem_write_data;
  logic [DW-1:0] b_mem_read_data = '0, b_s1 = '0, b_s2 = '0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_funct3(m0_funct3), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_funct3(m1_funct3), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_write_en(mem_write_en), .mem_funct3(mem_funct3), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_read_address(mem_read_address), .mem_read_data(mem_read_data)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_funct3(b_m0_funct3), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
    .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
    .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_funct3(b_m1_funct3), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
    .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
    .mem_write_en(b_mem_write_en), .mem_funct3(b_mem_funct3), .mem_write_address(b_mem_write_address),
    .mem_write_data(b_mem_write_data), .mem_read_address(b_mem_read_address), .mem_read_data(b_mem_read_data)
  );

  function automatic logic [DW-1:0] init_word(logic [AW-1:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  // Memory behind the main instance: one-cycle registered read, write on strobe.
  logic [DW-1:0] mem [logic [AW-1:0]];
  function automatic logic [DW-1:0] mem_rd(logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : init_word(a);
  endfunction
  always @(posedge clk) begin
    mem_read_data <= mem_rd(mem_read_address);
    if (mem_write_en) mem[mem_write_address] = mem_write_data;
  end

  // Three-stage read pipe for the long-latency instance.
  always @(posedge clk) begin
    b_s1            <= b_mem_read_address ^ 32'hA5A5_0000;
    b_s2            <= b_s1;
    b_mem_read_data <= b_s2;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mk counts cycles since the capture edge (0 = idle); the access
  // phase lasts 1 cycle for writes, RL for reads, followed by one response cycle.
  int            mk = 0;
  logic          mo = 1'b0, mrr = 1'b0, mwe = 1'b0;
  logic [2:0]    mf3 = '0;
  logic [AW-1:0] maddr = '0;
  logic [DW-1:0] mwdata = '0, mrdata = '0;
  logic [DW-1:0] mdl_mem [logic [AW-1:0]];

  function automatic int alen();
    return mwe ? 1 : int'(RL);
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      mk = 0; mrr = 1'b0;
    end else if (mk == 0) begin
      if (m0_req || m1_req) begin
        mo     = (m0_req && m1_req) ? mrr : m1_req;
        mrr    = !mo;
        mwe    = mo ? m1_we     : m0_we;
        mf3    = mo ? m1_funct3 : m0_funct3;
        maddr  = mo ? m1_addr   : m0_addr;
        mwdata = mo ? m1_wdata  : m0_wdata;
        mrdata = mdl_mem.exists(maddr) ? mdl_mem[maddr] : init_word(maddr);
        mk     = 1;
      end
    end else if (mk == alen() + 1) begin
      mk = 0;
    end else begin
      if (mk == 1 && mwe) mdl_mem[maddr] = mwdata;
      mk++;
    end
  endtask

  task automatic compare();
    logic busy, resp;
    busy = (mk != 0);
    resp = (mk == alen() + 1);
    chk("m0_gnt",    m0_gnt,    (mk == 1) && !mo);
    chk("m1_gnt",    m1_gnt,    (mk == 1) && mo);
    chk("m0_rvalid", m0_rvalid, resp && !mo);
    chk("m1_rvalid", m1_rvalid, resp && mo);
    chk("m0_rdata",  m0_rdata,  (resp && !mo && !mwe) ? mrdata : '0);
    chk("m1_rdata",  m1_rdata,  (resp && mo && !mwe) ? mrdata : '0);
    chk("mem_write_en",      mem_write_en,      (mk == 1) && mwe);
    chk("mem_funct3",        mem_funct3,        busy ? mf3 : 3'd0);
    chk("mem_write_address", mem_write_address, (busy && mwe) ? maddr : '0);
    chk("mem_write_data",    mem_write_data,    (busy && mwe) ? mwdata : '0);
    chk("mem_read_address",  mem_read_address,  (busy && !mwe) ? maddr : '0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (mk != 0 && n < 20) begin cycle(); n++; end
    chk("wait_idle_timeout", mk != 0, 0);
  endtask

  task automatic new_m0();
    m0_we = 1'($urandom_range(0, 1)); m0_funct3 = 3'($urandom);
    m0_addr = 32'h2000 + 32'($urandom_range(0, 15)) * 4; m0_wdata = $urandom;
  endtask

  task automatic new_m1();
    m1_we = 1'($urandom_range(0, 1)); m1_funct3 = 3'($urandom);
    m1_addr = 32'h2000 + 32'($urandom_range(0, 15)) * 4; m1_wdata = $urandom;
  endtask

  int order[$];
  int exp_alt[6] = '{0, 1, 0, 1, 0, 1};

  initial begin
    rst_n = 1'b0;
    {m0_req, m0_we, m0_funct3, m0_addr, m0_wdata} = '0;
    {m1_req, m1_we, m1_funct3, m1_addr, m1_wdata} = '0;
    {b_m0_req, b_m0_we, b_m0_funct3, b_m0_addr, b_m0_wdata} = '0;
    {b_m1_req, b_m1_we, b_m1_funct3, b_m1_addr, b_m1_wdata} = '0;
    repeat (3) cycle();
    chk("reset_strobes", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_write_en}, 0);
    rst_n = 1'b1;
    cycle();

    // m0 word write to 0x1000.
    m0_req = 1'b1; m0_we = 1'b1; m0_funct3 = 3'b010; m0_addr = 32'h0000_1000; m0_wdata = 32'hDEAD_BEEF;
    cycle();
    chk("wr_gnt", {m0_gnt, m1_gnt}, 2'b10);
    chk("wr_we", mem_write_en, 1);
    chk("wr_addr", mem_write_address, 32'h0000_1000);
    chk("wr_data", mem_write_data, 32'hDEAD_BEEF);
    chk("wr_f3", mem_funct3, 3'b010);
    m0_req = 1'b0;
    cycle();
    chk("wr_rvalid", {m0_rvalid, m1_rvalid, mem_write_en}, 3'b100);
    cycle();
    chk("wr_idle", {mem_write_address, mem_write_data}, 0);

    // m1 reads the word back.
    m1_req = 1'b1; m1_we = 1'b0; m1_funct3 = 3'b010; m1_addr = 32'h0000_1000;
    cycle();
    chk("rd_gnt", {m0_gnt, m1_gnt}, 2'b01);
    chk("rd_addr0", mem_read_address, 32'h0000_1000);
    m1_req = 1'b0;
    cycle();
    chk("rd_rvalid", {m0_rvalid, m1_rvalid}, 2'b01);
    chk("rd_addr1", mem_read_address, 32'h0000_1000);
    chk("rd_data", m1_rdata, 32'hDEAD_BEEF);
    chk("rd_other", m0_rdata, 0);
    wait_idle();

    // Both requesters held high: strict alternation starting at m0.
    m0_req = 1'b1; m1_req = 1'b1; new_m0(); new_m1();
    for (int c = 0; c < 60 && order.size() < 6; c++) begin
      cycle();
      chk("both_gnt", m0_gnt && m1_gnt, 0);
      if (m0_gnt) begin order.push_back(0); new_m0(); end
      if (m1_gnt) begin order.push_back(1); new_m1(); end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    chk("alt_count", order.size(), 6);
    for (int i = 0; i < order.size() && i < 6; i++) chk("alt_order", order[i], exp_alt[i]);
    wait_idle();

    // m1 raises req while m0's read is in flight.
    m0_req = 1'b1; m0_we = 1'b0; m0_funct3 = 3'b100; m0_addr = 32'h0000_1000;
    cycle();
    chk("late_m0_gnt", m0_gnt, 1);
    m0_req = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_funct3 = 3'b000; m1_addr = 32'h0000_2004;
    cycle();
    chk("late_resp", {m0_rvalid, m1_gnt}, 2'b10);
    chk("late_rdata", m0_rdata, 32'hDEAD_BEEF);
    cycle();
    chk("late_idle_gnt", m1_gnt, 0);
    cycle();
    chk("late_m1_gnt", m1_gnt, 1);
    m1_req = 1'b0;
    wait_idle();

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      cycle();
      if (m0_req) begin
        if (m0_gnt) begin m0_req = 1'($urandom_range(0, 1)); new_m0(); end
      end else if ($urandom_range(0, 2) == 0) begin
        m0_req = 1'b1; new_m0();
      end
      if (m1_req) begin
        if (m1_gnt) begin m1_req = 1'($urandom_range(0, 1)); new_m1(); end
      end else if ($urandom_range(0, 2) == 0) begin
        m1_req = 1'b1; new_m1();
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    wait_idle();
    cycle();

    // Reset during a write access.
    m0_req = 1'b1; m0_we = 1'b1; m0_funct3 = 3'b010; m0_addr = 32'h0000_3000; m0_wdata = 32'h1234_5678;
    cycle();
    chk("abort_we_before", mem_write_en, 1);
    m0_req = 1'b0;
    #1 rst_n = 1'b0;
    mk = 0; mrr = 1'b0;
    #1;
    chk("abort_we_async", mem_write_en, 0);
    chk("abort_gnt", m0_gnt, 0);
    repeat (2) cycle();
    chk("abort_no_rvalid", {m0_rvalid, m1_rvalid}, 0);
    rst_n = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_2000;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_2008;
    cycle();
    chk("post_rst_gnt", {m0_gnt, m1_gnt}, 2'b10);
    m0_req = 1'b0; m1_req = 1'b0;
    wait_idle();

    // Three-cycle latency instance: m0 read of 0x40.
    b_m0_req = 1'b1; b_m0_we = 1'b0; b_m0_funct3 = 3'b100; b_m0_addr = 32'h0000_0040;
    cycle();
    chk("l3_gnt", {b_m0_gnt, b_m1_gnt}, 2'b10);
    chk("l3_addr1", b_mem_read_address, 32'h0000_0040);
    b_m0_req = 1'b0;
    for (int k = 2; k <= 3; k++) begin
      cycle();
      chk("l3_no_rvalid", {b_m0_gnt, b_m0_rvalid}, 0);
      chk("l3_addr_hold", b_mem_read_address, 32'h0000_0040);
    end
    cycle();
    chk("l3_rvalid", {b_m0_rvalid, b_m1_rvalid}, 2'b10);
    chk("l3_rdata", b_m0_rdata, 32'hA5A5_0040);
    chk("l3_addr4", b_mem_read_address, 32'h0000_0040);
    chk("l3_f3", b_mem_funct3, 3'b100);
    cycle();
    chk("l3_idle", {b_m0_rvalid, b_mem_read_address}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
